// File: rtl/fifo_credit_tx_if.sv
// Handshake bundle between the credit-based fifo transmitter and its neighbours.
// The master modport is the transmitter's view; the slave modport is the environment's view.
interface fifo_credit_tx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             push;
    logic [WIDTH-1:0] wdata;
    logic             credit_return;
    logic             flush;
    logic             flush_done;
    logic [CW-1:0]    credits;
    logic             credit_err;

    modport master (
        input  in_valid,
        input  in_data,
        input  credit_return,
        input  flush,
        output in_ready,
        output push,
        output wdata,
        output flush_done,
        output credits,
        output credit_err
    );

    modport slave (
        output in_valid,
        output in_data,
        output credit_return,
        output flush,
        input  in_ready,
        input  push,
        input  wdata,
        input  flush_done,
        input  credits,
        input  credit_err
    );
endinterface

// File: rtl/fifo_credit_tx.sv
// Credit-based transmitter feeding a remote fifo of DEPTH entries, with a flush/drain sequence.
// Define FIFO_CREDIT_TX_ERR_EN to build the sticky credit-overflow detector.
module fifo_credit_tx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    fifo_credit_tx_if.master     bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        RUN,
        FLUSH_WAIT,
        FLUSH_DONE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    credits_reg;
    logic [CW-1:0]    credits_next;
    logic             push_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic             in_ready;
    logic             accept;

    assign in_ready = (state_reg == RUN) && (credits_reg != '0);
    assign accept   = bus.in_valid && in_ready;

    // A simultaneous accept and return cancel; a return at full credit saturates.
    always_comb begin
        credits_next = credits_reg;
        if (accept && !bus.credit_return) begin
            credits_next = credits_reg - CW'(1);
        end else if (!accept && bus.credit_return && (credits_reg != DEPTH_C)) begin
            credits_next = credits_reg + CW'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:        if (bus.flush) state_next = FLUSH_WAIT;
            FLUSH_WAIT: if (credits_next == DEPTH_C) state_next = FLUSH_DONE;
            FLUSH_DONE: state_next = RUN;
            default:    state_next = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= RUN;
            credits_reg <= DEPTH_C;
            push_reg    <= 1'b0;
            wdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            credits_reg <= credits_next;
            push_reg    <= accept;
            if (accept) begin
                wdata_reg <= bus.in_data;
            end
        end
    end

`ifdef FIFO_CREDIT_TX_ERR_EN
    logic credit_err_reg;

    // A return while every credit is already home means the remote side miscounted.
    always_ff @(posedge clock) begin
        if (reset) begin
            credit_err_reg <= 1'b0;
        end else if (bus.credit_return && !accept && (credits_reg == DEPTH_C)) begin
            credit_err_reg <= 1'b1;
        end
    end

    assign bus.credit_err = credit_err_reg;
`else
    assign bus.credit_err = 1'b0;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.push       = push_reg;
    assign bus.wdata      = wdata_reg;
    assign bus.credits    = credits_reg;
    assign bus.flush_done = (state_reg == FLUSH_DONE);
endmodule
